avalon_accumulator: RTL and testbench

Avalon-MM responder peripheral for the Nios II system that replaces the software-polled switch/LED/accumulate PIO trio with one register-mapped block. Synchronizes and debounces the accumulate key, adds the switch value into an 8-bit accumulator in hardware on each press, and drives the LEDs. Exposes snapshot, accumulator, control/status and event-count registers to the processor, plus an interrupt. Sits inside the SoC on the system clock, with `sw`, `key_n` and `led` exported to top-level pins.

---
 rtl/avalon_accumulator.sv | 163 ++++++++++++++++
 tb/tb_avalon_accumulator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_accumulator.sv
// Avalon-MM switch/key accumulator peripheral: synchronized, debounced key
// press adds the switch value into an 8-bit accumulator, with IRQ and press count.
module avalon_accumulator #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    input  logic [7:0]  sw,
    input  logic        key_n,
    output logic [7:0]  led,
    output logic        irq
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_SW    = 2'd0;
    localparam logic [1:0] ADDR_ACC   = 2'd1;
    localparam logic [1:0] ADDR_CTRL  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    logic [7:0]       sw_s1, sw_s2;
    logic             key_s1, key_s2;
    logic             stable_q, stable_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             press;

    logic [7:0]  acc_q, acc_n;
    logic        pend_q, pend_n, irq_en_q, irq_en_n, auto_q, auto_n, ovf_q, ovf_n;
    logic [15:0] count_q, count_n;
    logic [8:0]  sum;
    logic [31:0] rd_mux;
    logic [31:0] rd_data_q;
    logic        rd_pend_q;
    logic        wr_acc, wr_ctrl, wr_count;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata[31:8];

    // Debounce: a new level must persist DEBOUNCE_CYCLES edges; only 1->0 is a press
    always_comb begin
        cnt_n    = cnt_q;
        stable_n = stable_q;
        press    = 1'b0;
        if (key_s2 == stable_q) begin
            cnt_n = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_n = key_s2;
            cnt_n    = '0;
            press    = stable_q;
        end else begin
            cnt_n = cnt_q + CNT_W'(1);
        end
    end

    assign wr_acc   = avs_write && (avs_address == ADDR_ACC);
    assign wr_ctrl  = avs_write && (avs_address == ADDR_CTRL);
    assign wr_count = avs_write && (avs_address == ADDR_COUNT);
    assign sum      = {1'b0, acc_q} + {1'b0, sw_s2};

    // Register update: software writes apply first, then event sets win on W1C bits,
    // while ACC and COUNT writes override the event's result
    always_comb begin
        acc_n    = acc_q;
        pend_n   = pend_q;
        irq_en_n = irq_en_q;
        auto_n   = auto_q;
        ovf_n    = ovf_q;
        count_n  = count_q;

        if (wr_ctrl) begin
            pend_n   = pend_q & ~avs_writedata[0];
            irq_en_n = avs_writedata[1];
            auto_n   = avs_writedata[2];
            ovf_n    = ovf_q & ~avs_writedata[3];
        end

        if (press) begin
            pend_n = 1'b1;
            if (count_q != 16'hFFFF) begin
                count_n = count_q + 16'd1;
            end
            if (auto_q) begin
                acc_n = sum[7:0];
                if (sum[8]) begin
                    ovf_n = 1'b1;
                end
            end
        end

        if (wr_acc) begin
            acc_n = avs_writedata[7:0];
        end
        if (wr_count) begin
            count_n = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_SW:    rd_mux = {24'd0, sw_s2};
            ADDR_ACC:   rd_mux = {24'd0, acc_q};
            ADDR_CTRL:  rd_mux = {28'd0, ovf_q, auto_q, irq_en_q, pend_q};
            ADDR_COUNT: rd_mux = {16'd0, count_q};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_s1             <= '0;
            sw_s2             <= '0;
            key_s1            <= 1'b1;
            key_s2            <= 1'b1;
            stable_q          <= 1'b1;
            cnt_q             <= '0;
            acc_q             <= '0;
            pend_q            <= 1'b0;
            irq_en_q          <= 1'b0;
            auto_q            <= 1'b0;
            ovf_q             <= 1'b0;
            count_q           <= '0;
            rd_data_q         <= '0;
            rd_pend_q         <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
            led               <= '0;
            irq               <= 1'b0;
        end else begin
            sw_s1             <= sw;
            sw_s2             <= sw_s1;
            key_s1            <= key_n;
            key_s2            <= key_s1;
            stable_q          <= stable_n;
            cnt_q             <= cnt_n;
            acc_q             <= acc_n;
            pend_q            <= pend_n;
            irq_en_q          <= irq_en_n;
            auto_q            <= auto_n;
            ovf_q             <= ovf_n;
            count_q           <= count_n;
            // Capture pre-write contents on the strobe edge, present one edge later
            rd_pend_q         <= avs_read;
            if (avs_read) begin
                rd_data_q <= rd_mux;
            end
            avs_readdatavalid <= rd_pend_q;
            if (rd_pend_q) begin
                avs_readdata <= rd_data_q;
            end
            led               <= acc_n;
            irq               <= irq_en_n & pend_n;
        end
    end

endmodule

// File: tb/tb_avalon_accumulator.sv
// Scoreboarded bench for avalon_accumulator with a short debounce window.
module tb_avalon_accumulator;

    localparam int unsigned DEB = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [7:0]  sw;
    logic        key_n;
    logic [7:0]  led;
    logic        irq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } rd_exp_t;
    rd_exp_t rd_q[$];

    avalon_accumulator #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .sw                (sw),
        .key_n             (key_n),
        .led               (led),
        .irq               (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Read monitor: every valid pulse must match the oldest outstanding read
    always @(negedge clk) begin
        if (avs_readdatavalid) begin
            if (rd_q.size() == 0) begin
                check("rd_spurious", 32'd1, 32'd0);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_data", avs_readdata, e.data);
                check("rd_lat", cyc, e.due);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
        rd_exp_t e;
        e.data = exp;
        e.due  = cyc + 2;
        rd_q.push_back(e);
        avs_address = a;
        avs_read    = 1'b1;
        tick(1);
        avs_read    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && rd_q.size() != 0; i++) tick(1);
        if (rd_q.size() != 0) begin
            check("rd_drain", 32'(rd_q.size()), 32'd0);
            rd_q.delete();
        end
    endtask

    task automatic press_key();
        key_n = 1'b0;
        tick(DEB + 3);
        key_n = 1'b1;
        tick(DEB + 3);
    endtask

    // Press whose accept edge coincides with a software write
    task automatic press_with_write(input logic [1:0] a, input logic [31:0] d);
        key_n = 1'b0;
        tick(DEB + 1);
        bus_write(a, d);
        tick(1);
        key_n = 1'b1;
        tick(DEB + 3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        sw            = 8'hFF;
        key_n         = 1'b0;
        tick(2);
        check("rst_led", 32'(led), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdv", 32'(avs_readdatavalid), 32'd0);
        reset_n = 1'b1;
        key_n   = 1'b1;
        bus_read(2'd1, 32'd0);
        bus_read(2'd2, 32'd0);
        bus_read(2'd3, 32'd0);
        drain();
        tick(8);
        bus_read(2'd0, 32'h0000_00FF);
        bus_read(2'd3, 32'd0);
        drain();

        // Reset in the middle of a debounce window discards it
        key_n = 1'b0;
        tick(4);
        reset_n = 1'b0;
        key_n   = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(8);
        bus_read(2'd3, 32'd0);
        drain();
        check("midrst_led", 32'(led), 32'd0);

        // Debounce latency: accept at edge 2+DEB
        bus_write(2'd2, 32'h4);
        bus_write(2'd1, 32'h5);
        sw = 8'h03;
        tick(3);
        key_n = 1'b0;
        tick(DEB + 1);
        check("led_pre", 32'(led), 32'h05);
        tick(1);
        check("led_post", 32'(led), 32'h08);
        check("irq_off", 32'(irq), 32'd0);
        bus_read(2'd1, 32'h08);
        bus_read(2'd3, 32'd1);
        bus_read(2'd2, 32'h5);
        drain();
        key_n = 1'b1;
        tick(8);

        // Short glitch: no event
        key_n = 1'b0;
        tick(DEB - 1);
        key_n = 1'b1;
        tick(10);
        bus_read(2'd3, 32'd1);
        bus_read(2'd1, 32'h08);
        drain();

        // Overflow wrap and interrupt
        bus_write(2'd2, 32'h7);
        check("irq_clr", 32'(irq), 32'd0);
        bus_write(2'd1, 32'hF0);
        sw = 8'h20;
        tick(3);
        press_key();
        check("ovf_led", 32'(led), 32'h10);
        check("ovf_irq", 32'(irq), 32'd1);
        bus_read(2'd2, 32'hF);
        bus_read(2'd1, 32'h10);
        bus_read(2'd3, 32'd2);
        drain();
        bus_write(2'd2, 32'h0B);
        check("w1c_irq", 32'(irq), 32'd0);
        bus_read(2'd2, 32'h2);
        drain();

        // Read latency and ordering
        sw = 8'hA5;
        tick(3);
        bus_read(2'd0, 32'h0000_00A5);
        bus_read(2'd1, 32'h10);
        bus_read(2'd3, 32'd2);
        drain();

        // Read and write on the same edge returns the pre-write value
        begin
            rd_exp_t e;
            e.data = 32'h10;
            e.due  = cyc + 2;
            rd_q.push_back(e);
        end
        avs_address   = 2'd1;
        avs_writedata = 32'h33;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick(1);
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        bus_read(2'd1, 32'h33);
        drain();

        // Collisions between software writes and a press
        bus_write(2'd2, 32'h4);
        press_with_write(2'd1, 32'h77);
        check("col_led", 32'(led), 32'h77);
        bus_read(2'd1, 32'h77);
        bus_read(2'd3, 32'd3);
        bus_read(2'd2, 32'h5);
        drain();
        press_with_write(2'd3, 32'hDEAD);
        bus_read(2'd3, 32'd0);
        bus_read(2'd1, 32'h1C);
        bus_read(2'd2, 32'hD);
        drain();
        press_with_write(2'd2, 32'h0D);
        bus_read(2'd2, 32'h5);
        bus_read(2'd1, 32'hC1);
        bus_read(2'd3, 32'd1);
        drain();

        // COUNT saturation from a preloaded value
        force dut.count_q = 16'hFFFE;
        tick(1);
        release dut.count_q;
        bus_read(2'd3, 32'h0000_FFFE);
        drain();
        press_key();
        bus_read(2'd3, 32'h0000_FFFF);
        drain();
        press_key();
        bus_read(2'd3, 32'h0000_FFFF);
        drain();
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, 32'd0);
        drain();

        tick(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
